// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer for the 8-bit ALU datapath: fetches 9-bit instructions,
// decodes them onto the ALU/register-file controls and sequences data-memory transfers.
module ctrl_sequencer #(
  parameter int PC_W    = 10,
  parameter int DADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [8:0]      imem_data,
  output logic [2:0]      alu_cmd,
  output logic [1:0]      alu_immed,
  output logic            alu_direct,
  input  logic            br_logic,
  output logic [2:0]      rf_rd_a,
  output logic [2:0]      rf_rd_b,
  output logic            rf_we,
  output logic [2:0]      rf_wa,
  output logic            wb_sel,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic [PC_W-1:0] pc,
  output logic            br_flag,
  output logic            halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [2:0] OP_LDR   = 3'd0;
  localparam logic [2:0] OP_STR   = 3'd1;
  localparam logic [2:0] OP_CMP   = 3'd6;
  localparam logic [2:0] OP_BR    = 3'd7;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  // The data address is supplied by the register file, so only its width must be sane here.
  if (DADDR_W < 1) begin : g_bad_daddr
    $error("ctrl_sequencer: DADDR_W must be at least 1");
  end

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [8:0]      instr_q, instr_d;
  logic            br_flag_q, br_flag_d;

  logic [2:0]      op_s, rd_s, rs_s;
  logic [5:0]      off_s;
  logic [PC_W-1:0] br_off_s;
  logic            dec_s, alu_wr_s;

  assign op_s     = instr_q[8:6];
  assign rd_s     = instr_q[5:3];
  assign rs_s     = instr_q[2:0];
  assign off_s    = instr_q[5:0];
  assign br_off_s = {{(PC_W-6){instr_q[5]}}, instr_q[5:0]};
  assign dec_s    = (state_q == S_DECODE) || (state_q == S_EXEC) || (state_q == S_MEM);
  assign alu_wr_s = (op_s != OP_LDR) && (op_s != OP_STR) && (op_s != OP_CMP) && (op_s != OP_BR);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    br_flag_d = br_flag_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (op_s)
          OP_LDR, OP_STR: state_d = S_MEM;
          OP_CMP: begin
            br_flag_d = br_logic;
            pc_d      = pc_q + PC_ONE;
            state_d   = S_FETCH;
          end
          OP_BR: begin
            // A zero offset would spin forever, so it encodes HALT instead.
            if (off_s == 6'd0) begin
              state_d = S_HALT;
            end else if (br_flag_q) begin
              pc_d    = pc_q + br_off_s;
              state_d = S_FETCH;
            end else begin
              pc_d    = pc_q + PC_ONE;
              state_d = S_FETCH;
            end
          end
          default: begin
            pc_d    = pc_q + PC_ONE;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          pc_d    = pc_q + PC_ONE;
          state_d = S_FETCH;
        end else begin
          state_d = S_MEM;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      instr_q   <= 9'd0;
      br_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      br_flag_q <= br_flag_d;
    end
  end

  // Handshake and write strobes are held off while reset is asserted so nothing is issued mid-reset.
  always_comb begin
    imem_req   = rst_n && (state_q == S_FETCH);
    imem_addr  = pc_q;
    dmem_req   = rst_n && (state_q == S_MEM);
    dmem_we    = rst_n && (state_q == S_MEM) && (op_s == OP_STR);
    rf_we      = rst_n && (((state_q == S_EXEC) && alu_wr_s) ||
                           ((state_q == S_MEM) && (op_s == OP_LDR) && dmem_ack));
    wb_sel     = (state_q == S_MEM) && (op_s == OP_LDR);
    pc         = pc_q;
    br_flag    = br_flag_q;
    halted     = (state_q == S_HALT);
    if (dec_s) begin
      alu_cmd    = op_s;
      alu_immed  = instr_q[1:0];
      alu_direct = instr_q[2];
      rf_rd_a    = rd_s;
      rf_rd_b    = rs_s;
      rf_wa      = rd_s;
    end else begin
      alu_cmd    = 3'b111;
      alu_immed  = 2'b00;
      alu_direct = 1'b0;
      rf_rd_a    = 3'd0;
      rf_rd_b    = 3'd0;
      rf_wa      = 3'd0;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed scenarios plus randomized instruction
// streams checked against an instruction-level reference model.
module tb_ctrl_sequencer;
  localparam int PC_W = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_ack = 1'b0;
  logic [8:0]      imem_data = 9'd0;
  logic            br_logic = 1'b0;
  logic            dmem_ack = 1'b0;
  logic            imem_req, alu_direct, rf_we, wb_sel, dmem_req, dmem_we, br_flag, halted;
  logic [PC_W-1:0] imem_addr, pc;
  logic [2:0]      alu_cmd, rf_rd_a, rf_rd_b, rf_wa;
  logic [1:0]      alu_immed;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ctrl_sequencer #(.PC_W(PC_W), .DADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .alu_cmd(alu_cmd), .alu_immed(alu_immed),
    .alu_direct(alu_direct), .br_logic(br_logic), .rf_rd_a(rf_rd_a), .rf_rd_b(rf_rd_b),
    .rf_we(rf_we), .rf_wa(rf_wa), .wb_sel(wb_sel), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .pc(pc), .br_flag(br_flag), .halted(halted)
  );

  // Observations collected over one instruction
  logic [9:0] o_addr;
  logic       o_start_req, o_sel, o_dwe, o_dir, o_halt;
  logic [2:0] o_cmd, o_idle_cmd, o_rda, o_rdb, o_wa;
  logic [1:0] o_imm;
  int         o_cyc, o_we, o_dreq, o_ovl;

  // Reference model state and per-instruction expectations
  logic [9:0] m_pc;
  logic       m_flag;
  int         e_cyc, e_we, e_dreq;
  logic [2:0] e_wa;
  logic       e_sel, e_dwe, e_halt;

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; #1;
    m_pc = 10'd0; m_flag = 1'b0;
  endtask

  // Plays imem and dmem responder for one instruction, starting in FETCH at a sample point.
  task automatic do_instr(input logic [8:0] ins, input int iw, input int dw,
                          input logic brl, input bit noise);
    int dc;
    o_start_req = imem_req; o_addr = imem_addr; o_idle_cmd = alu_cmd;
    br_logic = brl; o_cyc = 0; o_we = 0; o_dreq = 0; o_ovl = 0;
    o_wa = 3'd0; o_sel = 1'b0; o_dwe = 1'b0; dc = 0;
    for (int i = 0; i < iw; i++) begin
      imem_ack = 1'b0;
      dmem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk); o_cyc++;
    end
    imem_ack = 1'b1; imem_data = ins; dmem_ack = 1'b0;
    @(negedge clk); o_cyc++;
    imem_ack = 1'b0;
    o_cmd = alu_cmd; o_imm = alu_immed; o_dir = alu_direct; o_rda = rf_rd_a; o_rdb = rf_rd_b;
    while (!imem_req && !halted && o_cyc < 64) begin
      if (dmem_req) begin
        dmem_ack = (dc == dw); dc++; o_dreq++; o_dwe = dmem_we;
        imem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        dmem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        imem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      #1;
      if (rf_we) begin o_we++; o_wa = rf_wa; o_sel = wb_sel; end
      @(negedge clk); o_cyc++;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0; #1;
    if (imem_req && (rf_we || dmem_req)) o_ovl++;
    o_halt = halted;
  endtask

  // Instruction-level reference: what one instruction must do, in architectural terms.
  task automatic model_step(input logic [8:0] ins, input logic brl, input int iw, input int dw);
    int off;
    off = int'($signed(ins[5:0]));
    e_we = 0; e_wa = ins[5:3]; e_sel = 1'b0; e_dreq = 0; e_dwe = 1'b0; e_halt = 1'b0;
    e_cyc = 3 + iw;
    case (ins[8:6])
      3'd0: begin e_we = 1; e_sel = 1'b1; e_dreq = dw + 1; e_cyc = 4 + iw + dw;
                  m_pc = 10'((int'(m_pc) + 1) % 1024); end
      3'd1: begin e_dreq = dw + 1; e_dwe = 1'b1; e_cyc = 4 + iw + dw;
                  m_pc = 10'((int'(m_pc) + 1) % 1024); end
      3'd6: begin m_flag = brl; m_pc = 10'((int'(m_pc) + 1) % 1024); end
      3'd7: begin
        if (off == 0) e_halt = 1'b1;
        else if (m_flag) m_pc = 10'((int'(m_pc) + off + 1024) % 1024);
        else m_pc = 10'((int'(m_pc) + 1) % 1024);
      end
      default: begin e_we = 1; m_pc = 10'((int'(m_pc) + 1) % 1024); end
    endcase
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    total++; if (imem_req !== 1'b0 || dmem_req !== 1'b0 || rf_we !== 1'b0 || dmem_we !== 1'b0) begin bad++; $display("FAIL reset_reqs got imem=%b dmem=%b we=%b dwe=%b want all 0", imem_req, dmem_req, rf_we, dmem_we); end
    total++; if (pc !== 10'd0 || br_flag !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL reset_state got pc=%0d flag=%b halted=%b want 0/0/0", pc, br_flag, halted); end
    total++; if (alu_cmd !== 3'b111 || rf_wa !== 3'd0 || rf_rd_a !== 3'd0 || rf_rd_b !== 3'd0 || wb_sel !== 1'b0) begin bad++; $display("FAIL reset_ctrl got cmd=%b wa=%0d ra=%0d rb=%0d sel=%b", alu_cmd, rf_wa, rf_rd_a, rf_rd_b, wb_sel); end
    rst_n = 1'b1; #1;
    m_pc = 10'd0; m_flag = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin bad++; $display("FAIL reset_fetch got req=%b addr=%0d want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_alu_program();
    logic [8:0] prog [3];
    logic [2:0] cmds [3];
    prog[0] = {3'b010, 3'd1, 3'b011};
    prog[1] = {3'b101, 3'd1, 3'b010};
    prog[2] = {3'b011, 3'd2, 3'd1};
    cmds[0] = 3'b010; cmds[1] = 3'b101; cmds[2] = 3'b011;
    for (int i = 0; i < 3; i++) begin
      do_instr(prog[i], 0, 0, 1'b0, 1'b0);
      model_step(prog[i], 1'b0, 0, 0);
      total++; if (o_cmd !== cmds[i]) begin bad++; $display("FAIL alu_cmd[%0d] got=%b want=%b", i, o_cmd, cmds[i]); end
      total++; if (o_cyc != 3 || o_we != 1) begin bad++; $display("FAIL alu_timing[%0d] got cyc=%0d we=%0d want 3/1", i, o_cyc, o_we); end
      total++; if (o_wa !== prog[i][5:3] || o_sel !== 1'b0) begin bad++; $display("FAIL alu_wb[%0d] got wa=%0d sel=%b want %0d/0", i, o_wa, o_sel, prog[i][5:3]); end
    end
    total++; if (pc !== 10'd3) begin bad++; $display("FAIL alu_pc got=%0d want=3", pc); end
  endtask

  task automatic test_ldr_wait();
    logic [8:0] ins;
    ins = {3'b000, 3'd4, 3'd5};
    do_instr(ins, 0, 4, 1'b0, 1'b0);
    model_step(ins, 1'b0, 0, 4);
    total++; if (o_dreq != 5 || o_dwe !== 1'b0) begin bad++; $display("FAIL ldr_dreq got cycles=%0d we=%b want 5/0", o_dreq, o_dwe); end
    total++; if (o_we != 1 || o_sel !== 1'b1 || o_wa !== 3'd4) begin bad++; $display("FAIL ldr_wb got we=%0d sel=%b wa=%0d want 1/1/4", o_we, o_sel, o_wa); end
    total++; if (pc !== 10'd4 || o_cyc != 8) begin bad++; $display("FAIL ldr_pc got pc=%0d cyc=%0d want 4/8", pc, o_cyc); end
  endtask

  task automatic test_branch();
    do_instr({3'b110, 3'd1, 3'd2}, 0, 0, 1'b1, 1'b0);
    total++; if (pc !== 10'd5 || br_flag !== 1'b1) begin bad++; $display("FAIL cmp_taken got pc=%0d flag=%b want 5/1", pc, br_flag); end
    do_instr({3'b111, 6'b111110}, 0, 0, 1'b0, 1'b0);
    total++; if (pc !== 10'd3 || br_flag !== 1'b1) begin bad++; $display("FAIL br_taken got pc=%0d flag=%b want 3/1", pc, br_flag); end
    do_instr({3'b010, 3'd0, 3'd0}, 0, 0, 1'b0, 1'b0);
    do_instr({3'b110, 3'd1, 3'd2}, 0, 0, 1'b0, 1'b0);
    total++; if (pc !== 10'd5 || br_flag !== 1'b0) begin bad++; $display("FAIL cmp_clear got pc=%0d flag=%b want 5/0", pc, br_flag); end
    do_instr({3'b111, 6'b111110}, 0, 0, 1'b1, 1'b0);
    total++; if (pc !== 10'd6 || br_flag !== 1'b0) begin bad++; $display("FAIL br_not_taken got pc=%0d flag=%b want 6/0", pc, br_flag); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    do_instr({3'b110, 3'd0, 3'd0}, 0, 0, 1'b1, 1'b0);
    do_instr({3'b111, 6'b111110}, 0, 0, 1'b0, 1'b0);
    total++; if (pc !== 10'd1023) begin bad++; $display("FAIL wrap_back got=%0d want=1023", pc); end
    do_instr({3'b111, 6'b000001}, 0, 0, 1'b0, 1'b0);
    total++; if (pc !== 10'd0 || imem_addr !== 10'd0) begin bad++; $display("FAIL wrap_fwd got pc=%0d addr=%0d want 0/0", pc, imem_addr); end
  endtask

  task automatic test_reset_mid_store();
    int we_seen;
    we_seen = 0;
    do_instr({3'b010, 3'd1, 3'd0}, 0, 0, 1'b0, 1'b0);
    imem_ack = 1'b1; imem_data = {3'b001, 3'd2, 3'd3};
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin bad++; $display("FAIL str_req got req=%b we=%b want 1/1", dmem_req, dmem_we); end
    rst_n = 1'b0;
    #1; if (rf_we) we_seen++;
    @(negedge clk);
    if (rf_we) we_seen++;
    total++; if (dmem_req !== 1'b0 || pc !== 10'd0 || we_seen != 0 || br_flag !== 1'b0) begin bad++; $display("FAIL rst_mid_str got req=%b pc=%0d we=%0d flag=%b want 0/0/0/0", dmem_req, pc, we_seen, br_flag); end
    rst_n = 1'b1; #1;
    m_pc = 10'd0; m_flag = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin bad++; $display("FAIL rst_resume got req=%b addr=%0d want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_halt();
    int reqs;
    logic [9:0] pc0;
    reqs = 0; pc0 = pc;
    do_instr(9'h1C0, 0, 0, 1'b0, 1'b0);
    total++; if (o_halt !== 1'b1 || o_cyc != 3 || pc !== pc0) begin bad++; $display("FAIL halt_enter got halted=%b cyc=%0d pc=%0d want 1/3/%0d", o_halt, o_cyc, pc, pc0); end
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom_range(0, 1)); dmem_ack = 1'($urandom_range(0, 1)); #1;
      if (imem_req || dmem_req || rf_we || pc !== pc0 || !halted) reqs++;
      @(negedge clk);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    total++; if (reqs != 0) begin bad++; $display("FAIL halt_quiet got activity=%0d want=0", reqs); end
    do_reset();
    total++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'd0) begin bad++; $display("FAIL halt_restart got halted=%b req=%b addr=%0d want 0/1/0", halted, imem_req, imem_addr); end
  endtask

  task automatic test_random();
    logic [8:0] ins;
    logic       brl;
    int         iw, dw;
    for (int n = 0; n < 250; n++) begin
      ins = 9'($urandom_range(0, 511));
      if (ins[8:6] == 3'b111 && ins[5:0] == 6'd0) ins[0] = 1'b1;
      brl = 1'($urandom_range(0, 1));
      iw = $urandom_range(0, 3); dw = $urandom_range(0, 3);
      total++; if (imem_req !== 1'b1 || imem_addr !== m_pc || alu_cmd !== 3'b111) begin bad++; $display("FAIL rnd_fetch[%0d] got req=%b addr=%0d cmd=%b want 1/%0d/111", n, imem_req, imem_addr, alu_cmd, m_pc); end
      do_instr(ins, iw, dw, brl, 1'b1);
      model_step(ins, brl, iw, dw);
      total++; if (o_cmd !== ins[8:6] || o_imm !== ins[1:0] || o_dir !== ins[2] || o_rda !== ins[5:3] || o_rdb !== ins[2:0]) begin bad++; $display("FAIL rnd_decode[%0d] ins=%h got cmd=%b imm=%b dir=%b ra=%0d rb=%0d", n, ins, o_cmd, o_imm, o_dir, o_rda, o_rdb); end
      total++; if (o_cyc != e_cyc || o_we != e_we || o_dreq != e_dreq || o_ovl != 0) begin bad++; $display("FAIL rnd_seq[%0d] ins=%h got cyc=%0d we=%0d dreq=%0d ovl=%0d want %0d/%0d/%0d/0", n, ins, o_cyc, o_we, o_dreq, o_ovl, e_cyc, e_we, e_dreq); end
      if (e_we != 0) begin
        total++; if (o_wa !== e_wa || o_sel !== e_sel) begin bad++; $display("FAIL rnd_wb[%0d] ins=%h got wa=%0d sel=%b want %0d/%b", n, ins, o_wa, o_sel, e_wa, e_sel); end
      end
      if (e_dreq != 0) begin
        total++; if (o_dwe !== e_dwe) begin bad++; $display("FAIL rnd_dwe[%0d] ins=%h got=%b want=%b", n, ins, o_dwe, e_dwe); end
      end
      total++; if (pc !== m_pc || br_flag !== m_flag || halted !== e_halt) begin bad++; $display("FAIL rnd_arch[%0d] ins=%h got pc=%0d flag=%b halted=%b want %0d/%b/%b", n, ins, pc, br_flag, halted, m_pc, m_flag, e_halt); end
    end
  endtask

  initial begin
    test_reset();
    test_alu_program();
    test_ldr_wait();
    test_branch();
    test_pc_wrap();
    test_reset_mid_store();
    test_halt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
